uart_apb_fifo_irq: RTL and testbench



---
 rtl/uart_apb_pkg.sv | 36 +++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_apb_fifo_irq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_apb_fifo_irq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART: register offsets (word index PADDR[4:2]),
// CTRL/STATUS/IE bit positions, TX/RX FSM state encodings and the frame parity helper.
package uart_apb_pkg;
    localparam logic [2:0] REG_TXDATA   = 3'd0;
    localparam logic [2:0] REG_RXDATA   = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_IE       = 3'd4;
    localparam logic [2:0] REG_THRESH   = 3'd5;
    localparam logic [2:0] REG_LEVEL    = 3'd6;
    localparam logic [2:0] REG_UNMAPPED = 3'd7;

    localparam int CTRL_BIT8     = 13;
    localparam int CTRL_PAR_EN   = 14;
    localparam int CTRL_ODD      = 15;
    localparam int CTRL_TWO_STOP = 16;
    localparam int CTRL_TX_EN    = 17;
    localparam int CTRL_RX_EN    = 18;

    localparam int ST_PERR = 4;
    localparam int ST_FERR = 5;
    localparam int ST_OVF  = 6;

    localparam int IE_RX_AVAIL  = 0;
    localparam int IE_TX_EMPTY  = 1;
    localparam int IE_ERR       = 2;
    localparam int IE_RX_THRESH = 3;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Parity bit value for the active data width; odd=1 makes the total count of ones odd.
    function automatic logic frame_parity(input logic [7:0] d, input logic bit8, input logic odd);
        return (^(bit8 ? d : {1'b0, d[6:0]})) ^ odd;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used for the UART TX (8b) and RX (9b) queues.
// Ports: clk, rst (sync active-high), push/wdata, pop/rdata (show-ahead head),
// full, empty, count. A push on a full FIFO succeeds when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_apb_fifo_irq.sv
// APB3 UART with TX/RX FIFOs, 16x baud generator, 7/8-bit framing with optional
// parity and 1/2 stop bits, sticky W1C error flags and a registered level IRQ.
// Ports: PCLK/PRESET (sync active-high), APB3 slave (PADDR, PSEL, PENABLE, PWRITE,
// PWDATA, PRDATA, PREADY, PSLVERR), RX serial in (async), TX serial out, IRQ.
module uart_apb_fifo_irq
    import uart_apb_pkg::*;
#(
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [4:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        TX,
    output logic        IRQ
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic [18:0] ctrl_q, ctrl_d;
    logic [3:0]  ie_q, ie_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [31:0] prdata_q, prdata_d, rd_mux;
    logic        rx_pop_ok_q, rx_pop_ok_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic        baud_en, tick16;
    tx_state_e   tx_state_q, tx_state_d;
    logic [4:0]  tx_tick_q, tx_tick_d, tx_last;
    logic [2:0]  tx_bit_q, tx_bit_d, last_bit;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_par_q, tx_par_d, tx_line_q, tx_line_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        rx_s, rx_prev_q, rx_mid, rx_end;
    rx_state_e   rx_state_q, rx_state_d;
    logic [4:0]  rx_tick_q, rx_tick_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_par_q, rx_par_d, rx_push, set_perr, set_ferr, set_ovf;
    logic        tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_rdata;
    logic [8:0]  rx_rdata;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    logic [15:0] tx_cnt16, rx_cnt16;
    logic [7:0]  tx_lvl, rx_lvl;
    logic        unused_bits;

    wire [2:0] sel      = PADDR[4:2];
    wire       setup_rd = PSEL & ~PENABLE & ~PWRITE;
    wire       acc_wr   = PSEL & PENABLE & PWRITE;
    wire       acc_rd   = PSEL & PENABLE & ~PWRITE;
    wire       bit8     = ctrl_q[CTRL_BIT8];
    wire       par_en   = ctrl_q[CTRL_PAR_EN];
    wire       odd      = ctrl_q[CTRL_ODD];

    assign PREADY      = 1'b1;
    assign PSLVERR     = PSEL & PENABLE & (sel == REG_UNMAPPED);
    assign PRDATA      = prdata_q;
    assign TX          = tx_line_q;
    assign IRQ         = irq_q;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:19]};

    assign tx_push  = acc_wr & (sel == REG_TXDATA);
    // Pop only a byte that the setup phase actually returned.
    assign rx_pop   = acc_rd & (sel == REG_RXDATA) & rx_pop_ok_q;
    assign tx_cnt16 = 16'(tx_count);
    assign rx_cnt16 = 16'(rx_count);
    assign tx_lvl   = (tx_cnt16 > 16'd255) ? 8'hFF : tx_cnt16[7:0];
    assign rx_lvl   = (rx_cnt16 > 16'd255) ? 8'hFF : rx_cnt16[7:0];

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop), .wdata(PWDATA[7:0]),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count));

    uart_sync_fifo #(.WIDTH(9), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .push(rx_push), .pop(rx_pop), .wdata({set_perr, rx_data_q}),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count));

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_RXDATA: if (!rx_empty) rd_mux = {23'd0, rx_rdata};
            REG_CTRL:   rd_mux = {13'd0, ctrl_q};
            REG_STATUS: rd_mux = {25'd0, ovf_q, ferr_q, perr_q, rx_full, rx_empty, tx_empty, tx_full};
            REG_IE:     rd_mux = {28'd0, ie_q};
            REG_THRESH: rd_mux = {24'd0, thresh_q};
            REG_LEVEL:  rd_mux = {8'd0, tx_lvl, 8'd0, rx_lvl};
            default:    rd_mux = '0;
        endcase
    end

    // Register file, sticky flags (a new error beats a same-cycle W1C), IRQ.
    always_comb begin
        ctrl_d      = ctrl_q;
        ie_d        = ie_q;
        thresh_d    = thresh_q;
        prdata_d    = prdata_q;
        rx_pop_ok_d = rx_pop_ok_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovf_d       = ovf_q;
        if (setup_rd) begin
            prdata_d    = rd_mux;
            rx_pop_ok_d = (sel == REG_RXDATA) & ~rx_empty;
        end
        if (acc_wr) begin
            case (sel)
                REG_CTRL:   ctrl_d   = PWDATA[18:0];
                REG_IE:     ie_d     = PWDATA[3:0];
                REG_THRESH: thresh_d = PWDATA[7:0];
                REG_STATUS: begin
                    if (PWDATA[ST_PERR]) perr_d = 1'b0;
                    if (PWDATA[ST_FERR]) ferr_d = 1'b0;
                    if (PWDATA[ST_OVF])  ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (set_perr) perr_d = 1'b1;
        if (set_ferr) ferr_d = 1'b1;
        if (set_ovf)  ovf_d  = 1'b1;
        irq_d = (ie_q[IE_RX_AVAIL] & ~rx_empty)
              | (ie_q[IE_TX_EMPTY] & tx_empty)
              | (ie_q[IE_ERR] & (perr_q | ferr_q | ovf_q))
              | (ie_q[IE_RX_THRESH] & (thresh_q != 8'd0) & (rx_cnt16 >= {8'd0, thresh_q}));
    end

    // Baud generator keeps running while a TX frame is in flight so a cleared tx_en finishes it.
    always_comb begin
        baud_en    = ctrl_q[CTRL_TX_EN] | ctrl_q[CTRL_RX_EN] | (tx_state_q != TX_IDLE);
        tick16     = baud_en & (baud_cnt_q >= ctrl_q[12:0]);
        baud_cnt_d = '0;
        if (baud_en && !tick16) baud_cnt_d = baud_cnt_q + 13'd1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        last_bit   = bit8 ? 3'd7 : 3'd6;
        tx_last    = (tx_state_q == TX_STOP && ctrl_q[CTRL_TWO_STOP]) ? 5'd31 : 5'd15;
        if (tx_state_q == TX_IDLE) begin
            if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_sh_d    = tx_rdata;
                tx_par_d   = frame_parity(tx_rdata, bit8, odd);
                tx_tick_d  = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_START;
            end
        end else if (tick16) begin
            tx_tick_d = tx_tick_q + 5'd1;
            if (tx_tick_q == tx_last) begin
                tx_tick_d = '0;
                case (tx_state_q)
                    TX_START:  tx_state_d = TX_DATA;
                    TX_DATA: begin
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == last_bit) tx_state_d = par_en ? TX_PARITY : TX_STOP;
                    end
                    TX_PARITY: tx_state_d = TX_STOP;
                    default:   tx_state_d = TX_IDLE;
                endcase
            end
        end
        // Line level follows the state one cycle later, so TX falls the cycle after the pop.
        case (tx_state_q)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_sh_q[0];
            TX_PARITY: tx_line_d = tx_par_q;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_s       = sync_q[SYNC_STAGES-1];
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        rx_mid     = tick16 & (rx_tick_q == 5'd7);
        rx_end     = tick16 & (rx_tick_q == 5'd15);
        if (rx_state_q != RX_IDLE && tick16) rx_tick_d = rx_tick_q + 5'd1;
        if (rx_end) rx_tick_d = '0;
        case (rx_state_q)
            RX_IDLE: if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_s) begin
                rx_state_d = RX_START;
                rx_tick_d  = '0;
                rx_bit_d   = '0;
                rx_data_d  = '0;
            end
            RX_START: begin
                if (rx_mid && rx_s)  rx_state_d = RX_IDLE;
                else if (rx_end)     rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_mid) rx_data_d[rx_bit_q] = rx_s;
                if (rx_end) begin
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == last_bit) rx_state_d = par_en ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_mid) rx_par_d = rx_s;
                if (rx_end) rx_state_d = RX_STOP;
            end
            default: if (rx_mid) begin
                // Byte completes at the first stop bit's midpoint; the rest of the stop time is idle.
                rx_state_d = RX_IDLE;
                if (!rx_s) set_ferr = 1'b1;
                else begin
                    rx_push  = 1'b1;
                    set_perr = par_en & (rx_par_q != frame_parity(rx_data_q, bit8, odd));
                end
            end
        endcase
        set_ovf = rx_push & rx_full & ~rx_pop;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q      <= '0;
            ie_q        <= '0;
            thresh_q    <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            prdata_q    <= '0;
            rx_pop_ok_q <= 1'b0;
            baud_cnt_q  <= '0;
            tx_state_q  <= TX_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_line_q   <= 1'b1;
            sync_q      <= '1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            ie_q        <= ie_d;
            thresh_q    <= thresh_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            prdata_q    <= prdata_d;
            rx_pop_ok_q <= rx_pop_ok_d;
            baud_cnt_q  <= baud_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_line_q   <= tx_line_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], RX};
            rx_prev_q   <= rx_s;
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
        end
    end

    always_ff @(posedge PCLK) begin
        tx_sh_q   <= tx_sh_d;
        tx_par_q  <= tx_par_d;
        rx_data_q <= rx_data_d;
        rx_par_q  <= rx_par_d;
    end
endmodule

// File: tb/tb_uart_apb_fifo_irq.sv
module tb_uart_apb_fifo_irq;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, rx, tx, irq;
    logic        loop, rx_drv;
    int          n_chk = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];
    logic        exp_bits[$];
    logic [31:0] rd;
    logic        err;

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    uart_apb_fifo_irq #(.TX_DEPTH(16), .RX_DEPTH(16), .SYNC_STAGES(2)) dut (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .RX(rx), .TX(tx), .IRQ(irq));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic slverr);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 slverr = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic slverr);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; slverr = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_read(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic pop_rx(input string tag);
        logic [31:0] d, e32;
        logic e;
        if (exp_q.size() != 0) e32 = {23'd0, exp_q.pop_front()};
        else e32 = 32'hFFFF_FFFF;
        apb_read(5'h04, d, e);
        check(tag, d, e32);
    endtask

    // Drive one 8-bit frame (start, LSB-first data, optional parity, one stop, one idle bit time).
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic odd,
                              input logic bad_par, input logic stop, input int bitc);
        rx_drv = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (bitc) @(negedge clk);
        end
        if (par_en) begin
            rx_drv = (^d) ^ odd ^ bad_par;
            repeat (bitc) @(negedge clk);
        end
        rx_drv = stop;
        repeat (bitc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic wait_rx_count(input logic [7:0] n, input string tag);
        logic [31:0] d;
        logic e;
        d = '0;
        for (int k = 0; k < 400; k++) begin
            apb_read(5'h18, d, e);
            if (d[7:0] == n) break;
            repeat (16) @(negedge clk);
        end
        check(tag, {24'd0, d[7:0]}, {24'd0, n});
    endtask

    task automatic measure(input logic lvl, output int c);
        c = 0;
        while (tx === lvl && c < 200) begin
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c1, c2;
        logic found;
        logic [7:0] a5;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        loop = 1'b0; rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("pready", {31'd0, pready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rd_check("rst_ctrl", 5'h08, 32'h0);
        rd_check("rst_status", 5'h0C, 32'h6);
        rd_check("rst_level", 5'h18, 32'h0);
        rd_check("rst_ie", 5'h10, 32'h0);
        rd_check("rst_thresh", 5'h14, 32'h0);
        rd_check("txdata_reads0", 5'h00, 32'h0);

        // TX framing: baud_div=3 -> 64 PCLK per bit, 8N1, byte 0xA5.
        wr(5'h08, 32'd3 | (32'd1 << 13) | (32'd1 << 17));
        a5 = 8'hA5;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(a5[i]);
        exp_bits.push_back(1'b1);
        wr(5'h00, 32'hA5);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (tx === 1'b0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("tx_start_seen", {31'd0, found}, 32'd1);
        check("tx_bit0", {31'd0, tx}, {31'd0, exp_bits.pop_front()});
        measure(1'b0, c1);
        check("tx_start_len_ok", {31'd0, (c1 >= 61 && c1 <= 64)}, 32'd1);
        check("tx_bit1", {31'd0, tx}, {31'd0, exp_bits.pop_front()});
        measure(1'b1, c2);
        check("tx_d0_len", c2, 32'd64);
        for (int i = 2; i < 10; i++) begin
            repeat ((i == 2) ? 31 : 64) @(negedge clk);
            check($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, exp_bits.pop_front()});
        end
        repeat (64) @(negedge clk);
        wr(5'h08, 32'h0);

        // Loopback, 8 bits, odd parity, two stop bits, baud_div=0.
        loop = 1'b1;
        wr(5'h08, (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 15) | (32'd1 << 16) | (32'd1 << 17) | (32'd1 << 18));
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(9'(i));
            wr(5'h00, 32'(i));
        end
        wait_rx_count(8'd16, "lb_level");
        rd_check("lb_status_full", 5'h0C, 32'h0A);
        for (int i = 0; i < 16; i++) pop_rx($sformatf("lb_data%0d", i));
        rd_check("lb_status_after", 5'h0C, 32'h06);
        repeat (64) @(negedge clk);
        wr(5'h08, 32'h0);
        repeat (40) @(negedge clk);
        loop = 1'b0;

        // Framing error with error interrupt, then W1C.
        wr(5'h08, 32'd1 | (32'd1 << 13) | (32'd1 << 18));
        wr(5'h10, 32'h4);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32);
        rd_check("ferr_status", 5'h0C, 32'h26);
        rd_check("ferr_level", 5'h18, 32'h0);
        check("ferr_irq", {31'd0, irq}, 32'd1);
        wr(5'h0C, 32'h20);
        rd_check("ferr_cleared", 5'h0C, 32'h06);
        check("ferr_irq_low", {31'd0, irq}, 32'd0);
        wr(5'h10, 32'h0);

        // Parity: one bad even-parity byte, then one good odd-parity byte.
        wr(5'h08, 32'd1 | (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 18));
        exp_q.push_back(9'h13C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 32);
        wr(5'h08, 32'd1 | (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 15) | (32'd1 << 18));
        exp_q.push_back(9'h081);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 32);
        rd_check("perr_status", 5'h0C, 32'h12);
        pop_rx("perr_data");
        pop_rx("par_ok_data");
        wr(5'h0C, 32'h10);
        rd_check("perr_cleared", 5'h0C, 32'h06);

        // Overflow: RX_DEPTH+1 frames without reading.
        wr(5'h08, 32'd1 | (32'd1 << 13) | (32'd1 << 18));
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(9'(8'h40 + i));
            send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b1, 32);
        end
        rd_check("ovf_status", 5'h0C, 32'h4A);
        rd_check("ovf_level", 5'h18, 32'h10);
        for (int i = 0; i < 16; i++) pop_rx($sformatf("ovf_data%0d", i));
        wr(5'h0C, 32'h40);
        rd_check("ovf_cleared", 5'h0C, 32'h06);
        rd_check("rx_empty_read", 5'h04, 32'h0);
        rd_check("rx_empty_level", 5'h18, 32'h0);

        // Threshold interrupt.
        wr(5'h14, 32'd4);
        wr(5'h10, 32'h8);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(9'(8'h60 + i));
            send_frame(8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b1, 32);
            repeat (4) @(negedge clk);
            check($sformatf("thr_irq%0d", i), {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
        end
        pop_rx("thr_data0");
        check("thr_irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1 check("thr_irq_drop", {31'd0, irq}, 32'd0);
        for (int i = 1; i < 4; i++) pop_rx($sformatf("thr_data%0d", i));

        // Unmapped offset: error response, read returns 0, write ignored.
        apb_read(5'h1C, rd, err);
        check("unmapped_rd_data", rd, 32'h0);
        check("unmapped_rd_err", {31'd0, err}, 32'd1);
        apb_write(5'h1C, 32'hFFFF_FFFF, err);
        check("unmapped_wr_err", {31'd0, err}, 32'd1);
        apb_read(5'h08, rd, err);
        check("ctrl_unchanged", rd, 32'd1 | (32'd1 << 13) | (32'd1 << 18));
        check("mapped_no_err", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
